// File: rtl/usb_tx_arbiter.sv
// rtl/usb_tx_arbiter.sv - frame-based round-robin arbiter for the USB CDC transmit byte channel
//
// Purpose:
//   Shares one USB CDC transmit byte channel between NUM_SRC response
//   generators. A granted source owns the channel until its last byte,
//   or until MAX_LEN bytes have gone out, whichever comes first.
//   Sources are served round-robin.
//
// Optional feature (macro TX_CHECKSUM_EN):
//   When defined, each frame is followed by one checksum byte: the
//   8-bit sum of the frame's bytes. When undefined, there is no
//   checksum state and no accumulator.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   src_data     byte per source; source i is bits [8i+7:8i]
//   src_valid    source i has a byte
//   src_last     source i's byte ends its frame
//   src_ready    byte accepted from source i
//   tx_data      byte to the USB CDC transmitter
//   tx_valid     tx_data is valid
//   tx_ready     USB CDC accepts the byte
//   busy         a frame (or its checksum) is in progress
//   grant_id     currently or most recently granted source
//   frame_err    one-cycle pulse when a frame is cut at MAX_LEN
module usb_tx_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int MAX_LEN = 64,
    parameter int GW      = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*NUM_SRC-1:0]   src_data,
    input  logic [NUM_SRC-1:0]     src_valid,
    input  logic [NUM_SRC-1:0]     src_last,
    output logic [NUM_SRC-1:0]     src_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic [GW-1:0]          grant_id,
    output logic                   frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_CSUM = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next_state;
    logic [GW-1:0] r_ptr;
    logic [GW-1:0] r_grant;
    logic [7:0]   r_cnt;
    logic         r_frame_err;
`ifdef TX_CHECKSUM_EN
    logic [7:0]   r_csum;
`endif

    logic [GW-1:0] w_sel;
    logic         w_any;
    logic         w_g_valid;
    logic         w_g_last;
    logic [7:0]   w_g_data;
    logic [7:0]   w_cnt_inc;
    logic         w_fire;
    logic         w_end;
    logic         w_force;

    assign w_any     = |src_valid;
    assign w_g_valid = src_valid[r_grant];
    assign w_g_last  = src_last[r_grant];
    assign w_g_data  = src_data[8*int'(r_grant) +: 8];
    assign w_cnt_inc = r_cnt + 8'd1;

    // Round-robin pick: first requester after the pointer, with wrap.
    // Scanning from the farthest offset down lets the nearest one win.
    always_comb begin
        w_sel = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            if (src_valid[(int'(r_ptr) + k) % NUM_SRC]) begin
                w_sel = GW'((int'(r_ptr) + k) % NUM_SRC);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        src_ready    = '0;
        w_fire       = 1'b0;
        w_end        = 1'b0;
        w_force      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_next_state = ST_XFER;
                end
            end
            ST_XFER: begin
                tx_data            = w_g_data;
                tx_valid           = w_g_valid;
                src_ready[r_grant] = tx_ready;
                w_fire             = w_g_valid && tx_ready;
                // A last byte wins over the length limit on the same beat.
                if (w_fire && (w_g_last || w_cnt_inc == 8'(MAX_LEN))) begin
                    w_end   = 1'b1;
                    w_force = !w_g_last;
`ifdef TX_CHECKSUM_EN
                    w_next_state = ST_CSUM;
`else
                    w_next_state = ST_IDLE;
`endif
                end
            end
`ifdef TX_CHECKSUM_EN
            ST_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = r_csum;
                if (tx_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
`endif
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= GW'(NUM_SRC - 1);
            r_grant     <= '0;
            r_cnt       <= 8'h00;
            r_frame_err <= 1'b0;
`ifdef TX_CHECKSUM_EN
            r_csum      <= 8'h00;
`endif
        end else begin
            r_state     <= w_next_state;
            r_frame_err <= w_force;
            if (r_state == ST_IDLE && w_any) begin
                r_grant <= w_sel;
                r_cnt   <= 8'h00;
`ifdef TX_CHECKSUM_EN
                r_csum  <= 8'h00;
`endif
            end
            if (w_fire) begin
                r_cnt  <= w_cnt_inc;
`ifdef TX_CHECKSUM_EN
                r_csum <= r_csum + w_g_data;
`endif
            end
            if (w_end) begin
                r_ptr <= r_grant;
            end
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign grant_id  = r_grant;
    assign frame_err = r_frame_err;

endmodule
